// File: rtl/m_rout_uart.sv
// m_rout_uart
// Watches the processor result word and reports every change over a UART TX
// line as eight uppercase ASCII hex digits followed by CR LF. Once the
// processor halts, one final frame tagged with a leading 'H' is sent and the
// block then stays silent until reset.
//
// Ports:
//   w_clk    system clock, all logic on posedge
//   w_rst_n  synchronous active-low reset
//   w_rout   32-bit processor result word, sampled every cycle
//   w_halt   processor halt flag (level, may stay high)
//   r_txd    UART TX, 8N1, LSB first, idle high
//   r_busy   high while any frame is being transmitted
//   r_done   sticky, high once the halt frame has completely finished
module m_rout_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic [31:0] w_rout,
  input  logic        w_halt,
  output logic        r_txd,
  output logic        r_busy,
  output logic        r_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    char_idx;
  logic [31:0]   shift_src;   // word whose digits the current frame carries
  logic          is_halt;     // current frame is the halt-tagged frame
  logic [7:0]    cur_byte;
  logic [31:0]   r_last;      // value most recently captured for sending
  logic [31:0]   pend;
  logic          pend_valid;
  logic          halt_seen;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Character idx of a frame. Halt frames carry a leading 'H', which shifts
  // the digit/CR/LF positions by one.
  function automatic logic [7:0] frame_char(input logic [31:0] word,
                                            input logic        halt_frm,
                                            input logic [3:0]  idx);
    logic [3:0] pos;
    logic [3:0] nib;
    pos = halt_frm ? (idx - 4'd1) : idx;
    case (pos[2:0])
      3'd0:    nib = word[31:28];
      3'd1:    nib = word[27:24];
      3'd2:    nib = word[23:20];
      3'd3:    nib = word[19:16];
      3'd4:    nib = word[15:12];
      3'd5:    nib = word[11:8];
      3'd6:    nib = word[7:4];
      default: nib = word[3:0];
    endcase
    if (halt_frm && idx == 4'd0) return 8'h48;
    else if (pos < 4'd8)         return hex_char(nib);
    else if (pos == 4'd8)        return 8'h0D;
    else                         return 8'h0A;
  endfunction

  logic [3:0] last_char;
  assign last_char = is_halt ? 4'd10 : 4'd9;

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      shift_src  <= '0;
      is_halt    <= 1'b0;
      cur_byte   <= '0;
      r_last     <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      halt_seen  <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_halt) halt_seen <= 1'b1;

      // While a frame is on the wire, pend tracks the latest word; it is only
      // worth sending if it differs from what was last captured. A word that
      // returns to r_last before the frame ends is therefore dropped.
      if (state != ST_IDLE) begin
        pend       <= w_rout;
        pend_valid <= (w_rout != r_last);
      end

      case (state)
        ST_IDLE: begin
          if (!r_done) begin
            if (w_rout != r_last) begin
              shift_src <= w_rout;
              r_last    <= w_rout;
              is_halt   <= 1'b0;
              cur_byte  <= frame_char(w_rout, 1'b0, 4'd0);
              char_idx  <= '0;
              clk_cnt   <= '0;
              r_txd     <= 1'b0;
              r_busy    <= 1'b1;
              state     <= ST_START;
            end else if (halt_seen) begin
              shift_src <= w_rout;
              is_halt   <= 1'b1;
              cur_byte  <= 8'h48;
              char_idx  <= '0;
              clk_cnt   <= '0;
              r_txd     <= 1'b0;
              r_busy    <= 1'b1;
              state     <= ST_START;
            end
          end
        end

        ST_START: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            r_txd   <= cur_byte[0];
            state   <= ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              r_txd <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              r_txd   <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (clk_cnt != CNT_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt <= '0;
            if (char_idx != last_char) begin
              // Next character follows immediately, no idle gap.
              char_idx <= char_idx + 4'd1;
              cur_byte <= frame_char(shift_src, is_halt, char_idx + 4'd1);
              r_txd    <= 1'b0;
              state    <= ST_START;
            end else begin
              // Frame end: decide what, if anything, goes out next.
              pend_valid <= 1'b0;
              char_idx   <= '0;
              if (is_halt) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                state  <= ST_IDLE;
              end else if (pend_valid && pend != r_last) begin
                shift_src <= pend;
                r_last    <= pend;
                is_halt   <= 1'b0;
                cur_byte  <= frame_char(pend, 1'b0, 4'd0);
                r_txd     <= 1'b0;
                state     <= ST_START;
              end else if (halt_seen && !r_done) begin
                shift_src <= w_rout;
                is_halt   <= 1'b1;
                cur_byte  <= 8'h48;
                r_txd     <= 1'b0;
                state     <= ST_START;
              end else begin
                r_busy <= 1'b0;
                state  <= ST_IDLE;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_rout_uart.sv
// Bench for m_rout_uart: two instances (4 and 1 clocks per bit) share the
// rout/halt stimulus and have separate resets. A UART decoder per instance
// collects received bytes; expected bytes are built from the frame format.
module tb_m_rout_uart;

  logic        clk = 1'b0;
  logic        rst4_n, rst1_n;
  logic [31:0] rout;
  logic        halt;
  logic        txd4, busy4, done4;
  logic        txd1, busy1, done1;

  always #5 clk = ~clk;

  m_rout_uart #(.CLKS_PER_BIT(4)) u_dut4 (
    .w_clk(clk), .w_rst_n(rst4_n), .w_rout(rout), .w_halt(halt),
    .r_txd(txd4), .r_busy(busy4), .r_done(done4)
  );

  m_rout_uart #(.CLKS_PER_BIT(1)) u_dut1 (
    .w_clk(clk), .w_rst_n(rst1_n), .w_rout(rout), .w_halt(halt),
    .r_txd(txd1), .r_busy(busy1), .r_done(done1)
  );

  logic txd_a [2];
  logic rst_a [2];
  logic busy_a [2];
  assign txd_a[0]  = txd4;
  assign txd_a[1]  = txd1;
  assign rst_a[0]  = rst4_n;
  assign rst_a[1]  = rst1_n;
  assign busy_a[0] = busy4;
  assign busy_a[1] = busy1;

  byte unsigned rxq [2][$];
  byte unsigned expq [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART receivers sampling at bit centres; a character cut by reset is dropped.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int CPB = (gi == 0) ? 4 : 1;
    int blen = 0;
    int bcur = 0;

    always @(negedge clk) begin
      bcur <= busy_a[gi] ? bcur + 1 : 0;
      if (!busy_a[gi] && bcur != 0) blen <= bcur;
    end

    initial begin
      logic [7:0] b;
      bit ok;
      int j;
      forever begin
        @(negedge clk);
        if (rst_a[gi] && txd_a[gi] === 1'b0) begin
          ok = 1'b1;
          b  = '0;
          for (int c = 0; c <= 9 * CPB + (CPB - 1) / 2; c++) begin
            if (c > 0) @(negedge clk);
            if (!rst_a[gi]) begin
              ok = 1'b0;
              break;
            end
            if (c % CPB == (CPB - 1) / 2) begin
              j = c / CPB;
              if (j == 0 && txd_a[gi] !== 1'b0) ok = 1'b0;
              else if (j >= 1 && j <= 8) b[j-1] = txd_a[gi];
              else if (j == 9 && txd_a[gi] !== 1'b1) ok = 1'b0;
            end
          end
          if (ok) rxq[gi].push_back(b);
        end
      end
    end
  end

  // Reference: frame = ['H'] + 8 uppercase hex digits + CR + LF.
  task automatic push_frame(input logic [31:0] w, input bit h);
    int d;
    if (h) expq.push_back(8'h48);
    for (int i = 7; i >= 0; i--) begin
      d = int'((w >> (4 * i)) & 32'hF);
      expq.push_back(byte'(d < 10 ? 48 + d : 65 + d - 10));
    end
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
  endtask

  task automatic cmp_rx(input int gi, input string tag);
    int n;
    check({tag, "_len"}, 64'(rxq[gi].size()), 64'(expq.size()));
    n = (rxq[gi].size() < expq.size()) ? rxq[gi].size() : expq.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(rxq[gi][i]), 64'(expq[i]));
    $display("txn %s: dut%0d received %0d bytes, expected %0d", tag, gi, rxq[gi].size(), expq.size());
    rxq[gi].delete();
    expq.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int gi, input int budget, input string tag);
    int n = 0;
    while (busy_a[gi] && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < budget), 64'd1);
    step(3);
  endtask

  task automatic chk_start(input int gi, input string tag);
    check({tag, "_txd0"}, 64'(txd_a[gi]), 64'd0);
    check({tag, "_busy1"}, 64'(busy_a[gi]), 64'd1);
  endtask

  logic [31:0] last_sent;
  logic [31:0] w1, w2;
  int bad;

  initial begin
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    rout   = 32'h0;
    halt   = 1'b0;
    step(3);
    check("rst_txd", 64'(txd4), 64'd1);
    check("rst_busy", 64'(busy4), 64'd0);
    check("rst_done", 64'(done4), 64'd0);
    rst4_n = 1'b1;

    // Zero held from reset: nothing sent.
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (txd4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) bad++;
    end
    check("idle_quiet", 64'(bad), 64'd0);
    check("idle_rx", 64'(rxq[0].size()), 64'd0);

    // Single change.
    rout = 32'h0000BEEF;
    step(1);
    chk_start(0, "beef");
    wait_idle(0, 2000, "beef");
    check("beef_busylen", 64'(g_mon[0].blen), 64'd400);
    push_frame(32'h0000BEEF, 1'b0);
    cmp_rx(0, "beef");

    // Two mid-frame changes: only the latest one follows, back to back.
    rout = 32'h12345678;
    step(1);
    chk_start(0, "latest");
    step(50);
    rout = 32'h1;
    step(50);
    rout = 32'h2;
    wait_idle(0, 2000, "latest");
    check("latest_busylen", 64'(g_mon[0].blen), 64'd800);
    push_frame(32'h12345678, 1'b0);
    push_frame(32'h2, 1'b0);
    cmp_rx(0, "latest");

    // Brief glitch returning to the value being sent: no extra frame.
    rout = 32'h0000BEEF;
    step(1);
    chk_start(0, "glitch");
    step(60);
    rout = 32'h3;
    step(10);
    rout = 32'h0000BEEF;
    wait_idle(0, 2000, "glitch");
    check("glitch_busylen", 64'(g_mon[0].blen), 64'd400);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (busy4 !== 1'b0) bad++;
    end
    check("glitch_quiet", 64'(bad), 64'd0);
    push_frame(32'h0000BEEF, 1'b0);
    cmp_rx(0, "glitch");
    last_sent = 32'h0000BEEF;

    // Random words, each optionally followed by a mid-frame change.
    for (int k = 0; k < 6; k++) begin
      do w1 = $urandom(); while (w1 == last_sent || w1 == 32'h0000BEEF);
      w2 = ($urandom_range(0, 1) == 0) ? w1 : $urandom();
      if (w2 == 32'h0000BEEF) w2 = w1;
      rout = w1;
      step(1);
      chk_start(0, $sformatf("rnd%0d", k));
      step($urandom_range(1, 300));
      rout = w2;
      wait_idle(0, 3000, $sformatf("rnd%0d", k));
      check($sformatf("rnd%0d_busylen", k), 64'(g_mon[0].blen), (w2 != w1) ? 64'd800 : 64'd400);
      push_frame(w1, 1'b0);
      if (w2 != w1) push_frame(w2, 1'b0);
      cmp_rx(0, $sformatf("rnd%0d", k));
      last_sent = w2;
    end

    // Reset in the data bits of char 3, then full resend.
    rout = 32'h0000BEEF;
    step(1);
    chk_start(0, "rst4");
    step(129);
    rst4_n = 1'b0;
    step(1);
    check("rst4_txd", 64'(txd4), 64'd1);
    check("rst4_busy", 64'(busy4), 64'd0);
    rst4_n = 1'b1;
    for (int i = 0; i < 3; i++) expq.push_back(8'h30);
    cmp_rx(0, "rst4_partial");
    step(1);
    chk_start(0, "rst4_resend");
    wait_idle(0, 2000, "rst4_resend");
    check("rst4_busylen", 64'(g_mon[0].blen), 64'd400);
    push_frame(32'h0000BEEF, 1'b0);
    cmp_rx(0, "rst4_resend");

    // Change and halt on the same edge: normal frame then halt frame.
    rout = 32'h7FFFF800;
    halt = 1'b1;
    step(1);
    chk_start(0, "halt");
    wait_idle(0, 3000, "halt");
    check("halt_busylen", 64'(g_mon[0].blen), 64'd840);
    check("halt_done", 64'(done4), 64'd1);
    push_frame(32'h7FFFF800, 1'b0);
    push_frame(32'h7FFFF800, 1'b1);
    cmp_rx(0, "halt");
    halt = 1'b0;
    rout = 32'h5;
    bad  = 0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (busy4 !== 1'b0 || txd4 !== 1'b1 || done4 !== 1'b1) bad++;
    end
    check("after_done_quiet", 64'(bad), 64'd0);
    cmp_rx(0, "after_done");

    // One clock per bit instance.
    rout   = 32'h0000BEEF;
    rst1_n = 1'b1;
    step(1);
    chk_start(1, "c1");
    wait_idle(1, 500, "c1");
    check("c1_busylen", 64'(g_mon[1].blen), 64'd100);
    push_frame(32'h0000BEEF, 1'b0);
    cmp_rx(1, "c1");
    rst1_n = 1'b0;
    step(1);
    rst1_n = 1'b1;
    step(1);
    chk_start(1, "c1_rst");
    step(34);
    rst1_n = 1'b0;
    step(1);
    check("c1_rst_txd", 64'(txd1), 64'd1);
    check("c1_rst_busy", 64'(busy1), 64'd0);
    rst1_n = 1'b1;
    for (int i = 0; i < 3; i++) expq.push_back(8'h30);
    cmp_rx(1, "c1_partial");
    step(1);
    chk_start(1, "c1_resend");
    wait_idle(1, 500, "c1_resend");
    check("c1_resend_busylen", 64'(g_mon[1].blen), 64'd100);
    push_frame(32'h0000BEEF, 1'b0);
    cmp_rx(1, "c1_resend");
    cmp_rx(0, "dut4_silent");
    check("dut4_done_sticky", 64'(done4), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
